// File: rtl/wire_cutter.sv
// Wire-cutting puzzle: three debounced pushbuttons drive a small game FSM
// (move a cursor over five wires, cut one), plus a registered 96x64 RGB565
// pixel generator for the OLED.

// One pushbutton channel: 2-FF synchronizer, then a debouncer. The counter
// advances only while the synchronized level disagrees with the debounced
// level. `rise` is a one-cycle pulse on each debounced rising edge.
module wire_cutter_debounce #(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic raw,
    output logic rise
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Synchronize, count disagreement, flip after DEBOUNCE_CYCLES cycles
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module wire_cutter #(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  pb,
    input  logic        arm,
    input  logic [2:0]  wire_to_cut,
    input  logic        pausesw,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    output logic [15:0] oled_data,
    output logic [2:0]  cursor,
    output logic [1:0]  strikes,
    output logic        defused,
    output logic        exploded
);
    localparam int NUM_BTN = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        DEFUSED  = 2'd2,
        EXPLODED = 2'd3
    } state_t;

    localparam logic [15:0] WIRE_COLOR [5] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hFFFF};

    // pb[1:0] are not wired to anything in this game
    logic unused_pb;
    assign unused_pb = ^pb[1:0];

    // Button channels: [0] LEFT, [1] RIGHT, [2] CTRL
    logic [NUM_BTN-1:0] btn_rise;

    wire_cutter_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db [NUM_BTN-1:0] (
        .CLK  (CLK),
        .RESET(RESET),
        .raw  (pb[4:2]),
        .rise (btn_rise)
    );

    // Paused events are dropped outright, never held for later
    logic ev_left, ev_right, ev_ctrl;
    assign ev_left  = btn_rise[0] & ~pausesw;
    assign ev_right = btn_rise[1] & ~pausesw;
    assign ev_ctrl  = btn_rise[2] & ~pausesw;

    state_t     state, state_n;
    logic [2:0] cursor_n;
    logic [1:0] strikes_n;
    logic [4:0] cut_mask, cut_n;
    logic [2:0] target, target_n;

    // Game state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            cursor   <= 3'd0;
            strikes  <= 2'd0;
            cut_mask <= 5'd0;
            target   <= 3'd0;
        end else begin
            state    <= state_n;
            cursor   <= cursor_n;
            strikes  <= strikes_n;
            cut_mask <= cut_n;
            target   <= target_n;
        end
    end

    // Next-state: arming, cursor moves, cuts and strikes. CTRL wins over
    // LEFT/RIGHT; LEFT and RIGHT together cancel out.
    always_comb begin
        state_n   = state;
        cursor_n  = cursor;
        strikes_n = strikes;
        cut_n     = cut_mask;
        target_n  = target;
        case (state)
            IDLE: begin
                if (arm && wire_to_cut >= 3'd1 && wire_to_cut <= 3'd5) begin
                    target_n  = wire_to_cut - 3'd1;
                    cut_n     = 5'd0;
                    cursor_n  = 3'd0;
                    strikes_n = 2'd0;
                    state_n   = ARMED;
                end
            end
            ARMED: begin
                if (ev_ctrl) begin
                    if (!cut_mask[cursor]) begin
                        cut_n[cursor] = 1'b1;
                        if (cursor == target) begin
                            state_n = DEFUSED;
                        end else begin
                            strikes_n = strikes + 2'd1;
                            if (strikes == 2'd2) state_n = EXPLODED;
                        end
                    end
                end else if (ev_left && !ev_right) begin
                    cursor_n = (cursor == 3'd0) ? 3'd4 : cursor - 3'd1;
                end else if (ev_right && !ev_left) begin
                    cursor_n = (cursor == 3'd4) ? 3'd0 : cursor + 3'd1;
                end
            end
            default: ;
        endcase
    end

    assign defused  = (state == DEFUSED);
    assign exploded = (state == EXPLODED);

    // Pixel generator
    logic [15:0] bg, pix;
    logic [6:0]  cur_lo;
    assign cur_lo = 7'd10 + 7'd18 * {4'd0, cursor};

    // Background by state, wires over it (with a gap where cut), cursor bar last
    always_comb begin
        case (state)
            DEFUSED:  bg = 16'h0400;
            EXPLODED: bg = 16'h8000;
            default:  bg = 16'h0000;
        endcase
        pix = bg;
        if (state != IDLE && y >= 6'd8 && y <= 6'd55) begin
            for (int i = 0; i < 5; i++) begin
                if (x >= 7'(10 + 18 * i) && x <= 7'(13 + 18 * i) &&
                    !(cut_mask[i] && y >= 6'd28 && y <= 6'd35))
                    pix = WIRE_COLOR[i];
            end
        end
        if (state == ARMED && y >= 6'd58 && y <= 6'd61 &&
            x >= cur_lo && x <= cur_lo + 7'd3)
            pix = 16'h07FF;
    end

    // Registered pixel output
    always_ff @(posedge CLK) begin
        if (RESET) oled_data <= 16'h0000;
        else       oled_data <= pix;
    end
endmodule
